// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: one valid/ready handshake plus dest reg and result per source.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    wb_valid;
    logic [NUM_REQ*5-1:0]  wb_addr;
    logic [NUM_REQ*32-1:0] wb_data;
    logic [NUM_REQ-1:0]    wb_ready;

    modport master (output wb_valid, output wb_addr, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_addr, input wb_data, output wb_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ write-back sources onto the single register-file write port.
// Round-robin grant with a starvation override; x0 writes are accepted but dropped.
module regfile_wb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    regfile_wb_arbiter_if.slave   wb,
    output logic                  we_p2,
    output logic [4:0]            addr_p2,
    output logic [31:0]           din_p2,
    output logic [2:0]            grant_id,
    output logic                  x0_drop
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [3:0]         WAIT_MAX = 4'(MAX_WAIT);

    logic [2:0]  rr_ptr;
    logic [3:0]  wait_cnt [NUM_REQ];

    logic        force_hit;
    logic [2:0]  force_idx;
    logic        rr_hit;
    logic [2:0]  rr_idx;
    logic [2:0]  scan_idx;
    logic        grant_vld;
    logic [2:0]  sel;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= WAIT_MAX) ? WAIT_MAX : cnt + 4'd1;
    endfunction

    // Descending scans so the last hit is the lowest index / the nearest rr position.
    always_comb begin
        force_hit = 1'b0;
        force_idx = 3'd0;
        rr_hit    = 1'b0;
        rr_idx    = 3'd0;
        scan_idx  = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (wb.wb_valid[i] && wait_cnt[i] == WAIT_MAX) begin
                force_hit = 1'b1;
                force_idx = 3'(i);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = (rr_ptr >= 3'(NUM_REQ - k)) ? rr_ptr - 3'(NUM_REQ - k)
                                                   : rr_ptr + 3'(k);
            if (wb.wb_valid[scan_idx]) begin
                rr_hit = 1'b1;
                rr_idx = scan_idx;
            end
        end
        grant_vld   = reset && !hold && (force_hit || rr_hit);
        sel         = force_hit ? force_idx : rr_idx;
        sel_addr    = wb.wb_addr[int'(sel)*5 +: 5];
        sel_data    = wb.wb_data[int'(sel)*32 +: 32];
        wb.wb_ready = grant_vld ? (ONE_HOT0 << sel) : '0;
    end

    // Stage p2: registered write port, pointer and starvation counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_p2    <= 1'b0;
            addr_p2  <= 5'd0;
            din_p2   <= 32'd0;
            grant_id <= 3'd0;
            x0_drop  <= 1'b0;
            rr_ptr   <= 3'd0;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= 4'd0;
        end else begin
            we_p2   <= grant_vld && (sel_addr != 5'd0);
            x0_drop <= grant_vld && (sel_addr == 5'd0);
            if (grant_vld) begin
                grant_id <= sel;
                rr_ptr   <= (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
                if (sel_addr != 5'd0) begin
                    addr_p2 <= sel_addr;
                    din_p2  <= sel_data;
                end
            end
            if (!hold) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!wb.wb_valid[i] || (grant_vld && sel == 3'(i)))
                        wait_cnt[i] <= 4'd0;
                    else
                        wait_cnt[i] <= sat_inc(wait_cnt[i]);
                end
            end
        end
    end

endmodule
